// File: rtl/fifo_uart_tx_amisha_pkg.sv
// Purpose : shared types and default frame constants for the FIFO-fed UART transmitter.
// Contents: FSM state encoding, default DATA_BITS / STOP_BITS / CLKS_PER_BIT, FIFO word width.
package fifo_uart_tx_amisha_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DEF_DATA_BITS    = 8;
  localparam int unsigned DEF_STOP_BITS    = 1;
  localparam int unsigned DEF_CLKS_PER_BIT = 16;
  localparam int unsigned FIFO_W           = 8;

endpackage

// File: rtl/fifo_uart_tx_amisha_bit_timer.sv
// Purpose : loadable down-counter used to time serial bits and the stop period.
// Ports   : clk_amisha      - clock
//           reset_amisha    - async active-low reset (count cleared to 0)
//           i_load          - load i_load_val this cycle
//           i_load_val      - value to load (period length minus one)
//           o_last_amisha_c - combinational, 1 on the final cycle of the loaded period
module bit_timer_amisha #(
  parameter int unsigned W = 4
) (
  input  logic         clk_amisha,
  input  logic         reset_amisha,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_last_amisha_c
);

  logic [W-1:0] r_cnt;

  // Counts down to zero and parks there until reloaded.
  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_last_amisha_c = (r_cnt == '0);

endmodule

// File: rtl/fifo_uart_tx_amisha.sv
// Purpose : pops words from a first-word-fall-through FIFO and sends each as an
//           async serial frame (start bit, DATA_BITS data LSB first, STOP_BITS stop).
// Ports   : clk_amisha       - clock
//           reset_amisha     - async active-low reset
//           en_amisha        - allow new frames to start
//           empty_amisha     - FIFO empty flag
//           r_data_amisha    - FIFO head word
//           rd_amisha        - combinational FIFO pop strobe
//           tx_amisha        - registered serial line, idle high
//           busy_amisha      - registered, high while a frame is in progress
//           done_tick_amisha - combinational pulse on the last stop cycle
module fifo_uart_tx_amisha
  import fifo_uart_tx_amisha_pkg::*;
#(
  parameter int unsigned DATA_BITS    = DEF_DATA_BITS,
  parameter int unsigned STOP_BITS    = DEF_STOP_BITS,
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic              clk_amisha,
  input  logic              reset_amisha,
  input  logic              en_amisha,
  input  logic              empty_amisha,
  input  logic [FIFO_W-1:0] r_data_amisha,
  output logic              rd_amisha,
  output logic              tx_amisha,
  output logic              busy_amisha,
  output logic              done_tick_amisha
);

  localparam int unsigned TW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] STOP_LOAD = TW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  tx_state_e            r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shreg, w_shreg_nxt;
  logic [BW-1:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 r_busy;
  logic                 w_load;
  logic [TW-1:0]        w_load_val;
  logic                 w_last;
  logic                 w_stop_last;
  logic                 w_pop;

  bit_timer_amisha #(
    .W(TW)
  ) u_bit_timer (
    .clk_amisha      (clk_amisha),
    .reset_amisha    (reset_amisha),
    .i_load          (w_load),
    .i_load_val      (w_load_val),
    .o_last_amisha_c (w_last)
  );

  // State, shift register, bit counter and registered line outputs.
  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state / datapath decode; a pop overrides whatever STOP would have done.
  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_tx_nxt      = r_tx;
    w_load        = 1'b0;
    w_load_val    = BIT_LOAD;

    w_stop_last = (r_state == ST_STOP) && w_last;
    // reset_amisha gating keeps the FIFO untouched while reset is held.
    w_pop = reset_amisha && en_amisha && !empty_amisha &&
            ((r_state == ST_IDLE) || w_stop_last);

    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
      end
      ST_START: begin
        if (w_last) begin
          w_state_nxt   = ST_DATA;
          w_tx_nxt      = r_shreg[0];
          w_bit_cnt_nxt = '0;
          w_load        = 1'b1;
        end
      end
      ST_DATA: begin
        if (w_last) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
            w_load      = 1'b1;
            w_load_val  = STOP_LOAD;
          end else begin
            w_shreg_nxt   = {1'b0, r_shreg[DATA_BITS-1:1]};
            w_tx_nxt      = r_shreg[1];
            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
            w_load        = 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (w_last) begin
          w_state_nxt = ST_IDLE;
          w_tx_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_pop) begin
      w_state_nxt = ST_START;
      w_shreg_nxt = r_data_amisha[DATA_BITS-1:0];
      w_tx_nxt    = 1'b0;
      w_load      = 1'b1;
      w_load_val  = BIT_LOAD;
    end
  end

  assign rd_amisha        = w_pop;
  assign done_tick_amisha = w_stop_last;
  assign tx_amisha        = r_tx;
  assign busy_amisha      = r_busy;

endmodule
